// File: rtl/pipe_pkg.sv
// Shared pipeline constants and RISC-V field-slice helpers for the ID/EX control slice.
// Pure combinational helpers; no state, no flow control.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [6:0]  OP_RTYPE   = 7'b0110011;
    localparam logic [6:0]  OP_ITYPE   = 7'b0010011;
    localparam logic [6:0]  OP_STYPE   = 7'b0100011;
    localparam logic [6:0]  OP_SBTYPE  = 7'b1100011;
    localparam int          CTRL_W_DEF = 8;

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    // Stores and branches reuse bits [11:7] as immediate, not a destination.
    function automatic logic f_writes_rd(input logic [31:0] instr);
        return (instr[6:0] != OP_STYPE) && (instr[6:0] != OP_SBTYPE);
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive held cycles and raises a sticky error once the run exceeds MAX_STALL.
// Error registers on the edge that completes the (MAX_STALL+1)-th held cycle; cleared only by reset.
module stall_watchdog #(
    parameter int MAX_STALL = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_flush,
    output logic o_stall_err
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);

    logic [RUN_W-1:0] r_run;
    logic             r_err;
    logic             w_held;

    assign w_held      = !i_load && !i_flush;
    assign o_stall_err = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run <= '0;
            r_err <= 1'b0;
        end else begin
            if (!w_held)
                r_run <= '0;
            else if (r_run != RUN_SAT)
                r_run <= r_run + RUN_W'(1);
            if (w_held && (r_run >= RUN_LIM))
                r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_pipe_ctrl.sv
// IF/ID and ID/EX pipeline registers applying hold, bubble and flush; optional perf counters (PIPE_PERF_CNT_EN).
// One cycle per stage; all outputs come straight from registers.
// Hold freezes IF/ID, bubble injects a NOP into EX, flush kills both stages and wins over everything.
module id_ex_pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int MAX_STALL = 3
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [XLEN-1:0]   i_if_pc,
    input  logic [31:0]       i_if_instr,
    input  logic              i_if_id_load,
    input  logic              i_bubble,
    input  logic              i_ex_flush,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic              i_id_is_branch,
    output logic [XLEN-1:0]   o_id_pc,
    output logic [31:0]       o_id_instr,
    output logic              o_id_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic [4:0]        o_ex_rd,
    output logic [4:0]        o_ex_rs1,
    output logic [4:0]        o_ex_rs2,
    output logic              o_ex_valid,
    output logic              o_ex_is_branch,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt,
`endif
    output logic              o_stall_err
);

    logic [XLEN-1:0]   r_id_pc;
    logic [31:0]       r_id_instr;
    logic              r_id_valid;
    logic [XLEN-1:0]   r_ex_pc;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [4:0]        r_ex_rd, r_ex_rs1, r_ex_rs2;
    logic              r_ex_valid, r_ex_is_branch;
    logic [4:0]        w_id_rd;

    // A dead or NOP slot must never look like a producer to the hazard unit.
    assign w_id_rd = (r_id_valid && (r_id_instr != NOP_INSTR) && f_writes_rd(r_id_instr))
                     ? f_rd(r_id_instr) : 5'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id_pc    <= '0;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (i_ex_flush) begin
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (i_if_id_load) begin
            r_id_pc    <= i_if_pc;
            r_id_instr <= i_if_instr;
            r_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_pc        <= '0;
            r_ex_ctrl      <= '0;
            r_ex_rd        <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_is_branch <= 1'b0;
        end else if (i_ex_flush || i_bubble) begin
            r_ex_ctrl      <= '0;
            r_ex_rd        <= '0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_valid     <= 1'b0;
            r_ex_is_branch <= 1'b0;
        end else begin
            r_ex_pc        <= r_id_pc;
            r_ex_ctrl      <= i_id_ctrl;
            r_ex_rd        <= w_id_rd;
            r_ex_rs1       <= f_rs1(r_id_instr);
            r_ex_rs2       <= f_rs2(r_id_instr);
            r_ex_valid     <= r_id_valid;
            r_ex_is_branch <= i_id_is_branch;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_bubble)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (i_ex_flush)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

    stall_watchdog #(.MAX_STALL(MAX_STALL)) u_stall_watchdog (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (i_if_id_load),
        .i_flush     (i_ex_flush),
        .o_stall_err (o_stall_err)
    );

    assign o_id_pc        = r_id_pc;
    assign o_id_instr     = r_id_instr;
    assign o_id_valid     = r_id_valid;
    assign o_ex_pc        = r_ex_pc;
    assign o_ex_ctrl      = r_ex_ctrl;
    assign o_ex_rd        = r_ex_rd;
    assign o_ex_rs1       = r_ex_rs1;
    assign o_ex_rs2       = r_ex_rs2;
    assign o_ex_valid     = r_ex_valid;
    assign o_ex_is_branch = r_ex_is_branch;

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// Directed bench for id_ex_pipe_ctrl: reset, capture, load-use stall, flush, watchdog, branch flag.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_id_ex_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = 32'h13;
    logic        if_id_load = 1'b0;
    logic        bubble = 1'b0;
    logic        ex_flush = 1'b0;
    logic [7:0]  id_ctrl = 8'h5A;
    logic        id_is_branch = 1'b0;
    logic [31:0] id_pc, id_instr, ex_pc;
    logic        id_valid, ex_valid, ex_is_branch, stall_err;
    logic [7:0]  ex_ctrl;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    id_ex_pipe_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc), .i_if_instr(if_instr),
        .i_if_id_load(if_id_load), .i_bubble(bubble), .i_ex_flush(ex_flush),
        .i_id_ctrl(id_ctrl), .i_id_is_branch(id_is_branch),
        .o_id_pc(id_pc), .o_id_instr(id_instr), .o_id_valid(id_valid),
        .o_ex_pc(ex_pc), .o_ex_ctrl(ex_ctrl), .o_ex_rd(ex_rd), .o_ex_rs1(ex_rs1),
        .o_ex_rs2(ex_rs2), .o_ex_valid(ex_valid), .o_ex_is_branch(ex_is_branch),
`ifdef PIPE_PERF_CNT_EN
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt),
`endif
        .o_stall_err(stall_err)
    );

    task automatic tick;
        @(posedge clk);
        if (rst_n && bubble) exp_stall++;
        if (rst_n && ex_flush) exp_flush++;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; if_id_load = 1'b1; if_pc = 32'h40; if_instr = 32'h002081B3;
        tick(); tick();
        if_id_load = 1'b0; bubble = 1'b1;
        tick();
        #2 rst_n = 1'b0; exp_stall = 0; exp_flush = 0;
        #1;
        n_chk++; if (id_instr !== 32'h13) $display("FAIL rst_id_instr got %h want 00000013", id_instr); else n_pass++;
        n_chk++; if (id_valid !== 1'b0) $display("FAIL rst_id_valid got %b want 0", id_valid); else n_pass++;
        n_chk++; if (id_pc !== 32'h0) $display("FAIL rst_id_pc got %h want 0", id_pc); else n_pass++;
        n_chk++; if (ex_ctrl !== 8'h0) $display("FAIL rst_ex_ctrl got %h want 00", ex_ctrl); else n_pass++;
        n_chk++; if (ex_rd !== 5'd0) $display("FAIL rst_ex_rd got %0d want 0", ex_rd); else n_pass++;
        n_chk++; if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid got %b want 0", ex_valid); else n_pass++;
        n_chk++; if (stall_err !== 1'b0) $display("FAIL rst_stall_err got %b want 0", stall_err); else n_pass++;
`ifdef PIPE_PERF_CNT_EN
        n_chk++; if (stall_cnt !== 32'd0) $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); else n_pass++;
`endif
        bubble = 1'b0; if_id_load = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_capture;
        if_id_load = 1'b1; if_pc = 32'h100; if_instr = 32'h00208033;
        tick();
        n_chk++; if (id_instr !== 32'h00208033) $display("FAIL cap_id_instr got %h want 00208033", id_instr); else n_pass++;
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 32'h100) $display("FAIL cap_id_vld_pc got %b/%h want 1/100", id_valid, id_pc); else n_pass++;
        if_pc = 32'h104; if_instr = 32'h002081B3;
        tick();
        n_chk++; if ({ex_rd, ex_rs1, ex_rs2} !== {5'd0, 5'd1, 5'd2}) $display("FAIL cap1_fields got %0d/%0d/%0d want 0/1/2", ex_rd, ex_rs1, ex_rs2); else n_pass++;
        n_chk++; if (ex_valid !== 1'b1 || ex_ctrl !== 8'h5A || ex_pc !== 32'h100) $display("FAIL cap1_ex got %b/%h/%h want 1/5a/100", ex_valid, ex_ctrl, ex_pc); else n_pass++;
        if_pc = 32'h108; if_instr = 32'h00310233;
        tick();
        n_chk++; if ({ex_rd, ex_rs1, ex_rs2} !== {5'd3, 5'd1, 5'd2}) $display("FAIL cap2_fields got %0d/%0d/%0d want 3/1/2", ex_rd, ex_rs1, ex_rs2); else n_pass++;
        n_chk++; if (ex_valid !== 1'b1 || ex_pc !== 32'h104) $display("FAIL cap2_ex got %b/%h want 1/104", ex_valid, ex_pc); else n_pass++;
    endtask

    task automatic test_load_use;
        if_id_load = 1'b0; bubble = 1'b1; if_pc = 32'h10C; if_instr = 32'h0020A223;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++; if (id_instr !== 32'h00310233) $display("FAIL lu_hold%0d got %h want 00310233", i, id_instr); else n_pass++;
            n_chk++; if (ex_ctrl !== 8'h0 || ex_valid !== 1'b0 || ex_rd !== 5'd0) $display("FAIL lu_nop%0d got %h/%b/%0d want 00/0/0", i, ex_ctrl, ex_valid, ex_rd); else n_pass++;
        end
        if_id_load = 1'b1; bubble = 1'b0;
        tick();
        n_chk++; if ({ex_rd, ex_rs1, ex_rs2} !== {5'd4, 5'd2, 5'd3} || ex_valid !== 1'b1) $display("FAIL lu_enter got %0d/%0d/%0d/%b want 4/2/3/1", ex_rd, ex_rs1, ex_rs2, ex_valid); else n_pass++;
        n_chk++; if (id_instr !== 32'h0020A223) $display("FAIL lu_next_id got %h want 0020a223", id_instr); else n_pass++;
`ifdef PIPE_PERF_CNT_EN
        n_chk++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
`endif
        if_pc = 32'h110; if_instr = 32'h13;
        tick();
        n_chk++; if ({ex_rd, ex_rs1, ex_rs2} !== {5'd0, 5'd1, 5'd2} || ex_valid !== 1'b1) $display("FAIL store_rd got %0d/%0d/%0d/%b want 0/1/2/1", ex_rd, ex_rs1, ex_rs2, ex_valid); else n_pass++;
    endtask

    task automatic test_flush;
        if_id_load = 1'b0; bubble = 1'b1; ex_flush = 1'b1; if_pc = 32'h200; if_instr = 32'h00208033;
        tick();
        n_chk++; if (id_valid !== 1'b0 || id_instr !== 32'h13) $display("FAIL fl_id got %b/%h want 0/00000013", id_valid, id_instr); else n_pass++;
        n_chk++; if (id_pc !== 32'h110) $display("FAIL fl_id_pc got %h want 110", id_pc); else n_pass++;
        n_chk++; if (ex_valid !== 1'b0) $display("FAIL fl_ex_valid got %b want 0", ex_valid); else n_pass++;
`ifdef PIPE_PERF_CNT_EN
        n_chk++; if (flush_cnt !== 32'(exp_flush)) $display("FAIL fl_flush_cnt got %0d want %0d", flush_cnt, exp_flush); else n_pass++;
        n_chk++; if (stall_cnt !== 32'(exp_stall)) $display("FAIL fl_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
`endif
        ex_flush = 1'b0; bubble = 1'b0;
        tick();
        n_chk++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) $display("FAIL fl_dead_slot got %b/%0d want 0/0", ex_valid, ex_rd); else n_pass++;
        if_id_load = 1'b1;
        tick();
    endtask

    task automatic test_watchdog;
        if_id_load = 1'b0;
        repeat (3) tick();
        if_id_load = 1'b1; tick();
        n_chk++; if (stall_err !== 1'b0) $display("FAIL wd_boundary got %b want 0", stall_err); else n_pass++;
        if_id_load = 1'b0;
        repeat (2) tick();
        ex_flush = 1'b1; tick();
        ex_flush = 1'b0;
        repeat (2) tick();
        n_chk++; if (stall_err !== 1'b0) $display("FAIL wd_flush_clears got %b want 0", stall_err); else n_pass++;
        if_id_load = 1'b1; tick();
        if_id_load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_chk++; if (stall_err !== (i == 4)) $display("FAIL wd_run%0d got %b want %b", i, stall_err, (i == 4)); else n_pass++;
        end
        if_id_load = 1'b1;
        repeat (2) tick();
        n_chk++; if (stall_err !== 1'b1) $display("FAIL wd_sticky got %b want 1", stall_err); else n_pass++;
    endtask

    task automatic test_branch;
        if_id_load = 1'b1; id_is_branch = 1'b1;
        tick();
        n_chk++; if (ex_is_branch !== 1'b1) $display("FAIL br_capture got %b want 1", ex_is_branch); else n_pass++;
        bubble = 1'b1;
        tick();
        n_chk++; if (ex_is_branch !== 1'b0 || ex_valid !== 1'b0) $display("FAIL br_bubble got %b/%b want 0/0", ex_is_branch, ex_valid); else n_pass++;
        bubble = 1'b0; id_is_branch = 1'b0;
    endtask

    task automatic test_reset_mid_stall;
        if_id_load = 1'b0;
        repeat (2) tick();
        #2 rst_n = 1'b0; exp_stall = 0; exp_flush = 0;
        #1;
        n_chk++; if (stall_err !== 1'b0 || id_valid !== 1'b0) $display("FAIL rst2_state got %b/%b want 0/0", stall_err, id_valid); else n_pass++;
`ifdef PIPE_PERF_CNT_EN
        n_chk++; if (flush_cnt !== 32'd0) $display("FAIL rst2_flush_cnt got %0d want 0", flush_cnt); else n_pass++;
`endif
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        #12;
        test_reset();
        test_capture();
        test_load_use();
        test_flush();
        test_watchdog();
        test_branch();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
